payload_engine_sched: RTL and testbench
=======================================

// Module: payload_engine_sched
// PURPOSE
// Per-packet sequencer for the payload_engine match array. Accepts a payload byte stream,
// clears all engine_* NFAs at start of packet (sod), steps them one byte per en pulse,
// flushes the End_state register after the last byte, then captures the sticky per-engine
// match vector and presents it as one result record per packet on a valid/ready port.
// PARAMETERS
// NUM_ENGINES   40    number of engine_* match outputs collected
// MAX_DEPTH     1460  bytes per packet fed to engines; later bytes consumed, not matched
// DRAIN_CYCLES  1     gated en pulses after last byte (End_state needs 1)
// LEN_W         16    width of byte counter / reported length
// PORTS
// clk           in   1            sole clock; all logic rising-edge
// resetn        in   1            synchronous, active-low reset
// s_data        in   8            payload byte
// s_sop         in   1            first byte of packet
// s_eop         in   1            last byte of packet
// s_valid       in   1            byte valid
// s_ready       out  1            byte accepted when s_valid & s_ready
// eng_byte      out  8            registered byte to char-class decoder
// eng_gate      out  1            1 = decoder outputs live; 0 = force all in_* low
// eng_en        out  1            engine step enable (FDCE CE)
// eng_sod       out  1            engine clear (FDCE CLR), active high
// match_in      in   NUM_ENGINES  engine out bits (sticky until sod)
// m_match       out  NUM_ENGINES  captured match vector
// m_len         out  LEN_W        bytes in packet (saturating)
// m_trunc       out  1            packet exceeded MAX_DEPTH
// m_err         out  1            protocol error (sop mid-packet)
// m_valid       out  1            result valid, held until m_ready
// m_ready       in   1            result consumer ready
// BEHAVIOUR
// - Reset (resetn=0 at edge): state=IDLE; s_ready=0, eng_en=0, eng_gate=0, eng_byte=0,
//   eng_sod=1, m_valid=0, m_match=0, m_len=0, m_trunc=0, m_err=0, counters=0.
// - FSM IDLE->CLEAR->RUN->DRAIN->SETTLE->REPORT->IDLE; all outputs registered.
// - IDLE: s_ready=0, eng_sod=0. s_valid&s_sop -> CLEAR. s_valid without sop: s_ready=1 for
//   that beat, byte dropped (inter-packet garbage discard), stay IDLE.
// - CLEAR: 1 cycle, eng_sod=1, s_ready=0, byte_cnt:=0, flags:=0 -> RUN.
// - RUN: s_ready=1. Accepted beat: byte_cnt++ (saturate at 2^LEN_W-1); next cycle
//   eng_byte=s_data, eng_gate=1, eng_en=(byte_cnt_before < MAX_DEPTH). Byte MAX_DEPTH+1
//   onward sets trunc, eng_en=0. s_sop on a beat after the first sets err, byte processed
//   as data. Accepted beat with s_eop -> DRAIN (s_ready=0 from next cycle). No beat:
//   eng_en=0. Latency s_data -> eng_byte = 1 cycle.
// - DRAIN: DRAIN_CYCLES cycles of eng_en=1, eng_gate=0 (propagates state regs to End_state
//   without new char matches) -> SETTLE.
// - SETTLE: 1 cycle, eng_en=0 (engine FF outputs settle) -> REPORT, latching
//   m_match=match_in, m_len=byte_cnt, m_trunc, m_err on entry edge.
// - REPORT: m_valid=1, fields stable; s_ready=0 (upstream back-pressured). m_valid&m_ready
//   -> m_valid=0, IDLE. No combinational path m_ready->s_ready.
// - sop&eop on same beat: 1-byte packet, RUN lasts that beat only.
// - Truncated packet still drained; engines saw only first MAX_DEPTH bytes.
// - resetn low mid-packet: immediate IDLE, partial result discarded, eng_sod=1 clears engines.
// - Throughput: one byte/cycle in RUN; per-packet overhead CLEAR+DRAIN+SETTLE+REPORT>=4 cycles.
// TESTING
// - Reset: resetn=0 3 cycles -> eng_sod=1, eng_en=0, s_ready=0, m_valid=0 every cycle.
// - "Server: Guptachar 1.2" sop..eop, engine 39 model attached -> m_match[39]=1, m_len=21,
//   trunc=0, err=0; exactly 21 gated eng_en + 1 ungated pulse.
// - MAX_DEPTH=4, 6-byte packet -> 4 eng_en with gate=1, m_len=6, m_trunc=1.
// - sop on 3rd beat of 5-byte packet -> m_err=1, m_len=5, single result record.
// - m_ready=0 for 10 cycles in REPORT, next packet waiting -> s_ready=0, m_* stable;
//   m_ready=1 -> handshake, next CLEAR pulse follows within 2 cycles.
// - resetn=0 for 1 cycle mid-RUN -> no result emitted; next packet reports only its own matches.

Source files
------------

// File: rtl/payload_engine_sched.sv
// payload_engine_sched: per-packet sequencer for the payload_engine match array.
// Clears the engines at start of packet, feeds one registered byte per accepted
// beat, runs the End_state drain pulses, lets the engine flops settle, then
// presents one captured result record per packet on a valid/ready port.
// DRAIN_CYCLES must be at least 1.
module payload_engine_sched #(
  parameter int NUM_ENGINES  = 40,
  parameter int MAX_DEPTH    = 1460,
  parameter int DRAIN_CYCLES = 1,
  parameter int LEN_W        = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  // payload byte stream
  input  logic [7:0]             s_data,
  input  logic                   s_sop,
  input  logic                   s_eop,
  input  logic                   s_valid,
  output logic                   s_ready,
  // engine array control
  output logic [7:0]             eng_byte,
  output logic                   eng_gate,
  output logic                   eng_en,
  output logic                   eng_sod,
  input  logic [NUM_ENGINES-1:0] match_in,
  // result record
  output logic [NUM_ENGINES-1:0] m_match,
  output logic [LEN_W-1:0]       m_len,
  output logic                   m_trunc,
  output logic                   m_err,
  output logic                   m_valid,
  input  logic                   m_ready
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    SETTLE,
    REPORT
  } state_t;

  localparam int                  DRAIN_W    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES);
  localparam logic [LEN_W-1:0]    DEPTH_LIM  = LEN_W'(MAX_DEPTH);

  state_t             state;
  logic [LEN_W-1:0]   byte_cnt;
  logic               trunc_flag;
  logic               err_flag;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               beat;

  assign beat = s_valid & s_ready;

  // Sequencer FSM; every output is a flop so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    // NOTE: state and outputs use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order inside this block.
    if (!resetn) begin
      state      <= IDLE;
      s_ready    <= 1'b0;
      eng_byte   <= '0;
      eng_gate   <= 1'b0;
      eng_en     <= 1'b0;
      eng_sod    <= 1'b1;
      m_match    <= '0;
      m_len      <= '0;
      m_trunc    <= 1'b0;
      m_err      <= 1'b0;
      m_valid    <= 1'b0;
      byte_cnt   <= '0;
      trunc_flag <= 1'b0;
      err_flag   <= 1'b0;
      drain_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          eng_sod  <= 1'b0;
          eng_en   <= 1'b0;
          eng_gate <= 1'b0;
          if (s_ready) begin
            // A non-sop beat was offered last cycle; it is consumed and dropped now.
            s_ready <= 1'b0;
          end else if (s_valid && s_sop) begin
            // Leave the sop beat pending; RUN accepts it as byte one.
            eng_sod <= 1'b1;
            state   <= CLEAR;
          end else if (s_valid) begin
            s_ready <= 1'b1;
          end
        end

        CLEAR: begin
          eng_sod    <= 1'b0;
          byte_cnt   <= '0;
          trunc_flag <= 1'b0;
          err_flag   <= 1'b0;
          s_ready    <= 1'b1;
          state      <= RUN;
        end

        RUN: begin
          eng_en   <= 1'b0;
          eng_gate <= 1'b0;
          if (beat) begin
            eng_byte <= s_data;
            eng_gate <= 1'b1;
            // Bytes past the match depth are consumed but never step the engines.
            eng_en   <= (byte_cnt < DEPTH_LIM);
            if (byte_cnt >= DEPTH_LIM) trunc_flag <= 1'b1;
            if (byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
            if (s_sop && (byte_cnt != '0)) err_flag <= 1'b1;
            if (s_eop) begin
              s_ready   <= 1'b0;
              drain_cnt <= '0;
              state     <= DRAIN;
            end
          end
        end

        DRAIN: begin
          // The first DRAIN cycle still shows the final byte on the engine port;
          // the following DRAIN_CYCLES cycles carry ungated step pulses.
          eng_gate <= 1'b0;
          if (drain_cnt == DRAIN_LAST) begin
            eng_en <= 1'b0;
            state  <= SETTLE;
          end else begin
            eng_en    <= 1'b1;
            drain_cnt <= drain_cnt + 1'b1;
          end
        end

        SETTLE: begin
          // Engines have taken their last step; capture the sticky match vector.
          m_match <= match_in;
          m_len   <= byte_cnt;
          m_trunc <= trunc_flag;
          m_err   <= err_flag;
          m_valid <= 1'b1;
          state   <= REPORT;
        end

        REPORT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_payload_engine_sched.sv
// Bench for payload_engine_sched. Two instances run in lockstep on one stream:
// dut_big uses the default depth, dut_small uses MAX_DEPTH=4. Each has a
// behavioural "Guptachar" engine on match bit 39; bits 38:0 are a per-packet
// random background vector. Expected records come from plain substring search
// and length arithmetic over the packet bytes.
module tb_payload_engine_sched;

  localparam logic [71:0] PAT = "Guptachar";

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_sop = 1'b0;
  logic        s_eop = 1'b0;
  logic        s_valid = 1'b0;
  logic        m_ready = 1'b0;
  logic [1:0]  s_ready;
  logic [7:0]  eng_byte [2];
  logic [1:0]  eng_gate, eng_en, eng_sod;
  logic [39:0] match_in [2];
  logic [39:0] m_match [2];
  logic [15:0] m_len [2];
  logic [1:0]  m_trunc, m_err, m_valid;

  logic [38:0] bg = '0;
  logic [7:0]  pkt [$];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  payload_engine_sched dut_big (
    .clk(clk), .resetn(resetn),
    .s_data(s_data), .s_sop(s_sop), .s_eop(s_eop), .s_valid(s_valid), .s_ready(s_ready[0]),
    .eng_byte(eng_byte[0]), .eng_gate(eng_gate[0]), .eng_en(eng_en[0]), .eng_sod(eng_sod[0]),
    .match_in(match_in[0]),
    .m_match(m_match[0]), .m_len(m_len[0]), .m_trunc(m_trunc[0]), .m_err(m_err[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready)
  );

  payload_engine_sched #(.MAX_DEPTH(4)) dut_small (
    .clk(clk), .resetn(resetn),
    .s_data(s_data), .s_sop(s_sop), .s_eop(s_eop), .s_valid(s_valid), .s_ready(s_ready[1]),
    .eng_byte(eng_byte[1]), .eng_gate(eng_gate[1]), .eng_en(eng_en[1]), .eng_sod(eng_sod[1]),
    .match_in(match_in[1]),
    .m_match(m_match[1]), .m_len(m_len[1]), .m_trunc(m_trunc[1]), .m_err(m_err[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready)
  );

  // Engine model: a 9-char window; a completed pattern reaches End_state one step later.
  logic [71:0] win [2];
  logic [1:0]  hit, end_st;
  logic [7:0]  ch;
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (eng_sod[i]) begin
        win[i]    <= '0;
        hit[i]    <= 1'b0;
        end_st[i] <= 1'b0;
      end else if (eng_en[i]) begin
        ch = eng_gate[i] ? eng_byte[i] : 8'h00;
        win[i]    <= {win[i][63:0], ch};
        hit[i]    <= ({win[i][63:0], ch} == PAT);
        end_st[i] <= end_st[i] | hit[i];
      end
    end
  end

  assign match_in[0] = eng_sod[0] ? '0 : {end_st[0], bg};
  assign match_in[1] = eng_sod[1] ? '0 : {end_st[1], bg};

  // Step-pulse counters per packet, cleared while the engines are cleared.
  int cnt_gated [2] = '{0, 0};
  int cnt_drain [2] = '{0, 0};
  int cnt_skip  [2] = '{0, 0};
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (eng_sod[i]) begin
        cnt_gated[i] <= 0;
        cnt_drain[i] <= 0;
        cnt_skip[i]  <= 0;
      end else begin
        if (eng_en[i] && eng_gate[i])  cnt_gated[i] <= cnt_gated[i] + 1;
        if (eng_en[i] && !eng_gate[i]) cnt_drain[i] <= cnt_drain[i] + 1;
        if (!eng_en[i] && eng_gate[i]) cnt_skip[i]  <= cnt_skip[i] + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pkt(input string s);
    pkt.delete();
    for (int i = 0; i < s.len(); i++) pkt.push_back(s[i]);
  endtask

  function automatic logic has_pat(input int lim);
    string p;
    logic  ok;
    p = "Guptachar";
    for (int s = 0; s + 9 <= lim; s++) begin
      ok = 1'b1;
      for (int k = 0; k < 9; k++) if (pkt[s+k] != p[k]) ok = 1'b0;
      if (ok) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Present one beat and hold it until both instances accept it.
  task automatic put_beat(input logic [7:0] d, input logic sop, input logic eop);
    int t;
    t = 0;
    s_data = d; s_sop = sop; s_eop = eop; s_valid = 1'b1;
    @(negedge clk);
    while (!(s_ready[0] && s_ready[1]) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("beat_accepted", 64'(t < 50), 64'd1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
  endtask

  // Send pkt, check both result records, hold m_ready low for 'hold' cycles,
  // then handshake. With chain set, the next sop beat waits during REPORT.
  task automatic run_packet(input string tag, input int sop_idx, input int hold,
                            input logic chain, input logic [7:0] chain_byte);
    int n, t, mx, lim;
    logic [39:0] em;
    n  = pkt.size();
    bg = 39'({$urandom(), $urandom()});
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      put_beat(pkt[i], (i == 0) || (i == sop_idx), i == n - 1);
    end
    if (chain) begin
      s_data = chain_byte; s_sop = 1'b1; s_eop = 1'b0; s_valid = 1'b1;
    end
    t = 0;
    @(negedge clk);
    while (!m_valid[0] && t < 100) begin
      @(negedge clk);
      t++;
    end
    for (int d = 0; d < 2; d++) begin
      mx  = (d == 0) ? 1460 : 4;
      lim = (n < mx) ? n : mx;
      em  = {has_pat(lim), bg};
      check($sformatf("%s_valid%0d", tag, d), m_valid[d], 1'b1);
      check($sformatf("%s_match%0d", tag, d), m_match[d], em);
      check($sformatf("%s_len%0d", tag, d), m_len[d], 64'(n));
      check($sformatf("%s_trunc%0d", tag, d), m_trunc[d], 64'(n > mx));
      check($sformatf("%s_err%0d", tag, d), m_err[d], 64'(sop_idx > 0 && sop_idx < n));
      check($sformatf("%s_gated%0d", tag, d), 64'(cnt_gated[d]), 64'(lim));
      check($sformatf("%s_skip%0d", tag, d), 64'(cnt_skip[d]), 64'(n - lim));
      check($sformatf("%s_drain%0d", tag, d), 64'(cnt_drain[d]), 64'd1);
    end
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check({tag, "_hold_sready"}, s_ready, 2'b00);
      check({tag, "_hold_valid"}, m_valid, 2'b11);
      check({tag, "_hold_match"}, m_match[0], {has_pat(n), bg});
      check({tag, "_hold_len"}, m_len[1], 64'(n));
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    check({tag, "_valid_drop"}, m_valid, 2'b00);
    if (chain) begin
      t = 1;
      while (!eng_sod[0] && t < 6) begin
        @(negedge clk);
        t++;
      end
      check({tag, "_clear_latency"}, 64'(t <= 2), 64'd1);
    end
  endtask

  initial begin
    int n, off, sop_idx, seen;
    string alpha;
    string pat_s;
    alpha = "Guptachr";
    pat_s = "Guptachar";

    // Reset held for three edges.
    repeat (3) begin
      @(negedge clk);
      check("rst_sod", eng_sod, 2'b11);
      check("rst_en", eng_en, 2'b00);
      check("rst_sready", s_ready, 2'b00);
      check("rst_mvalid", m_valid, 2'b00);
    end
    check("rst_gate", eng_gate[0], 1'b0);
    check("rst_byte", eng_byte[0], 8'h00);
    check("rst_match", m_match[0], 40'h0);
    check("rst_len", m_len[0], 16'h0);
    resetn = 1'b1;

    // Inter-packet garbage, then the reference header.
    put_beat(8'h55, 1'b0, 1'b0);
    put_beat(8'hAA, 1'b0, 1'b0);
    set_pkt("Server: Guptachar 1.2");
    run_packet("srv", -1, 0, 1'b0, 8'h00);

    set_pkt("abcdef");
    run_packet("depth", -1, 0, 1'b0, 8'h00);

    // Pattern completes on the final byte; only the drain pulse exposes it.
    set_pkt("xyGuptachar");
    run_packet("tail", -1, 0, 1'b0, 8'h00);

    // Extra sop on the third beat.
    set_pkt("ab?de");
    run_packet("err", 2, 0, 1'b0, 8'h00);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (m_valid[0]) seen = 1;
    end
    check("err_single_record", 64'(seen), 64'd0);

    // Consumer stalls 10 cycles while the next packet's sop waits.
    set_pkt("Guptachar");
    run_packet("hold", -1, 10, 1'b1, "Q");
    set_pkt("Q");
    run_packet("one", -1, 0, 1'b0, 8'h00);

    // Reset pulse mid-RUN: partial packet (already matched) must vanish.
    set_pkt("zzGuptacharzz");
    for (int i = 0; i < pkt.size(); i++) put_beat(pkt[i], i == 0, 1'b0);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (m_valid != 2'b00) seen = 1;
    end
    check("rst_mid_no_result", 64'(seen), 64'd0);
    set_pkt("hello");
    run_packet("postrst", -1, 0, 1'b0, 8'h00);

    // Randomized packets.
    for (int p = 0; p < 12; p++) begin
      repeat ($urandom_range(0, 2)) put_beat(8'($urandom()), 1'b0, 1'b0);
      n = $urandom_range(1, 14);
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back(alpha[$urandom_range(0, 7)]);
      if (n >= 9 && $urandom_range(0, 1) == 1) begin
        off = $urandom_range(0, n - 9);
        for (int k = 0; k < 9; k++) pkt[off+k] = pat_s[k];
      end
      sop_idx = (n > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : -1;
      run_packet($sformatf("rnd%0d", p), sop_idx, $urandom_range(0, 3), 1'b0, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
